// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hz_perf_cnt.sv
// Enabled, wrapping event counter with synchronous clear.
module hz_perf_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_Rt_i,
  input  logic [REG_W-1:0] IFID_Rs_i,
  input  logic [REG_W-1:0] IFID_Rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IF_Flush_o,
  output logic             ID_Flush_o,
  output logic             EX_Flush_o,
  output logic [1:0]       state_o,
  output logic             timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o
`endif
);

  localparam int unsigned TO_LAST = MEM_TIMEOUT - 1;

  hz_state_e  state_q, state_d;
  logic [4:0] wait_cnt_q;
  logic       timeout_q;
  logic       load_use;
  logic       timeout_hit;

  assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != '0) &&
                    ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  // The flag is visible in the same cycle the last allowed busy cycle is seen.
  assign timeout_hit = (state_q == MEM_WAIT) && mem_busy_i &&
                       (32'(wait_cnt_q) == TO_LAST);

  assign state_o   = state_q;
  assign timeout_o = !rst_i && (timeout_q || timeout_hit);

  always_comb begin
    PC_Write_o   = 1'b1;
    IFID_Write_o = 1'b1;
    IF_Flush_o   = 1'b0;
    ID_Flush_o   = 1'b0;
    EX_Flush_o   = 1'b0;
    state_d      = RUN;
    if (rst_i) begin
      PC_Write_o   = 1'b0;
      IFID_Write_o = 1'b0;
      IF_Flush_o   = 1'b1;
      ID_Flush_o   = 1'b1;
      EX_Flush_o   = 1'b1;
    end else if (mem_busy_i) begin
      PC_Write_o   = 1'b0;
      IFID_Write_o = 1'b0;
      state_d      = MEM_WAIT;
    end else if (branch_taken_i) begin
      IF_Flush_o   = 1'b1;
      ID_Flush_o   = 1'b1;
      EX_Flush_o   = 1'b1;
      state_d      = FLUSH;
    end else if ((state_q == RUN) && load_use) begin
      PC_Write_o   = 1'b0;
      IFID_Write_o = 1'b0;
      ID_Flush_o   = 1'b1;
      state_d      = LU_STALL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == MEM_WAIT) && mem_busy_i) begin
        if (wait_cnt_q != '1) begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_ev;

  assign flush_ev = !rst_i && !mem_busy_i && branch_taken_i;

  hz_perf_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!PC_Write_o),
    .cnt_o (stall_cnt_o)
  );

  hz_perf_cnt #(.WIDTH(32)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_ev),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_Rt_i;
  logic [4:0] IFID_Rs_i;
  logic [4:0] IFID_Rt_i;
  logic       branch_taken_i;
  logic       mem_busy_i;
  logic       PC_Write_o;
  logic       IFID_Write_o;
  logic       IF_Flush_o;
  logic       ID_Flush_o;
  logic       EX_Flush_o;
  logic [1:0] state_o;
  logic       timeout_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // {PC_Write, IFID_Write, IF_Flush, ID_Flush, EX_Flush}
  logic [4:0] ctl;
  assign ctl = {PC_Write_o, IFID_Write_o, IF_Flush_o, ID_Flush_o, EX_Flush_o};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_Rt_i      (IDEX_Rt_i),
    .IFID_Rs_i      (IFID_Rs_i),
    .IFID_Rt_i      (IFID_Rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .PC_Write_o     (PC_Write_o),
    .IFID_Write_o   (IFID_Write_o),
    .IF_Flush_o     (IF_Flush_o),
    .ID_Flush_o     (ID_Flush_o),
    .EX_Flush_o     (EX_Flush_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge and apply a new input vector.
  task automatic step(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic busy);
    @(posedge clk_i);
    #1;
    IDEX_MemRead_i = mr;
    IDEX_Rt_i      = ex_rt;
    IFID_Rs_i      = rs;
    IFID_Rt_i      = rt;
    branch_taken_i = br;
    mem_busy_i     = busy;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    IDEX_MemRead_i = 1'b0; IDEX_Rt_i = '0; IFID_Rs_i = '0; IFID_Rt_i = '0;
    branch_taken_i = 1'b0; mem_busy_i = 1'b0;
    @(negedge clk_i);
    total++; if (ctl !== 5'b00111) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00111); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 5'b11000); end
  endtask

  task automatic test_load_use;
    step(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0);
    total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, 5'b00010); end
    // hazard still visible in LU_STALL must not re-stall
    step(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL lu_state got=%0d exp=1", state_o); end
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL lu_stall_ctl got=%b exp=%b", ctl, 5'b11000); end
    step(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL lu_back_state got=%0d exp=0", state_o); end
    total++; if (ctl !== 5'b00010) begin bad++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, 5'b00010); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL lu_return got=%0d exp=0", state_o); end
  endtask

  task automatic test_zero_reg;
    step(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL zero_ctl got=%b exp=%b", ctl, 5'b11000); end
    step(1'b1, 5'd9, 5'd7, 5'd6, 1'b0, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL zero_state got=%0d exp=0", state_o); end
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL nomatch_ctl got=%b exp=%b", ctl, 5'b11000); end
  endtask

  task automatic test_branch;
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    total++; if (ctl !== 5'b11111) begin bad++; $display("FAIL br_ctl got=%b exp=%b", ctl, 5'b11111); end
    step(1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL br_state got=%0d exp=2", state_o); end
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL br_lu_ignored got=%b exp=%b", ctl, 5'b11000); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL br_return got=%0d exp=0", state_o); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    total++; if (ctl !== 5'b11111) begin bad++; $display("FAIL br_in_flush_ctl got=%b exp=%b", ctl, 5'b11111); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL br_b2b_state got=%0d exp=2", state_o); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_priority;
    step(1'b1, 5'd4, 5'd4, 5'd2, 1'b1, 1'b1);
    total++; if (ctl !== 5'b00000) begin bad++; $display("FAIL prio_ctl got=%b exp=%b", ctl, 5'b00000); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL prio_state got=%0d exp=3", state_o); end
    total++; if (ctl !== 5'b11000) begin bad++; $display("FAIL wait_exit_ctl got=%b exp=%b", ctl, 5'b11000); end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL wait_exit_state got=%0d exp=0", state_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL prio_timeout got=%b exp=0", timeout_o); end
  endtask

  task automatic test_timeout;
    logic       exp_to;
    logic [1:0] exp_st;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      exp_st = (i == 0) ? 2'd0 : 2'd3;
      exp_to = (i >= 4);
      total++; if (state_o !== exp_st) begin bad++; $display("FAIL to_state[%0d] got=%0d exp=%0d", i, state_o, exp_st); end
      total++; if (timeout_o !== exp_to) begin bad++; $display("FAIL to_flag[%0d] got=%b exp=%b", i, timeout_o, exp_to); end
    end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL to_after_state got=%0d exp=0", state_o); end
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_o); end
  endtask

  task automatic test_reset_mid_wait;
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL rmw_pre_state got=%0d exp=3", state_o); end
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (ctl !== 5'b00111) begin bad++; $display("FAIL rmw_ctl got=%b exp=%b", ctl, 5'b00111); end
    @(posedge clk_i); #1; rst_i = 1'b0; mem_busy_i = 1'b0;
    @(negedge clk_i);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rmw_state got=%0d exp=0", state_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rmw_timeout got=%b exp=0", timeout_o); end
`ifdef HAZARD_PERF_CNT_EN
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL rmw_stall_cnt got=%0d exp=0", stall_cnt_o); end
    total++; if (flush_cnt_o !== 32'd0) begin bad++; $display("FAIL rmw_flush_cnt got=%0d exp=0", flush_cnt_o); end
`endif
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt;
    step(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    total++; if (stall_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_stall got=%0d exp=2", stall_cnt_o); end
    total++; if (flush_cnt_o !== 32'd1) begin bad++; $display("FAIL perf_flush got=%0d exp=1", flush_cnt_o); end
  endtask
`endif

  initial begin
    test_reset;
    test_load_use;
    test_zero_reg;
    test_branch;
    test_priority;
    test_timeout;
    test_reset_mid_wait;
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the consecutive mem_busy_i cycles after which timeout_o sets.
REQ-003 IDEX_MemRead_i  input  1  instruction in ID/EX is a load.
REQ-004 IDEX_Rt_i  input  5  load destination register.
REQ-005 IFID_Rs_i, IFID_Rt_i  input  5 each  source registers of the instruction in IF/ID.
REQ-006 branch_taken_i  input  1  branch resolved taken in EX.
REQ-007 mem_busy_i  input  1  data memory not ready.
REQ-008 PC_Write_o, IFID_Write_o  output  1 each  PC and IF/ID register write enables.
REQ-009 IF_Flush_o, ID_Flush_o, EX_Flush_o  output  1 each  zero the IF/ID, ID/EX and EX/MEM registers.
REQ-010 state_o  output  2  current FSM state.
REQ-011 timeout_o  output  1  sticky memory-wait timeout flag.

Function
REQ-012 The FSM SHALL have states RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3, registered on clk_i.
REQ-013 Outputs SHALL be combinational from the state and current inputs.
REQ-014 Default outputs outside reset: PC_Write_o=1, IFID_Write_o=1, all flushes 0.
REQ-015 Input priority in every state SHALL be mem_busy_i > branch_taken_i > load-use.
REQ-016 Load-use SHALL be IDEX_MemRead_i=1, IDEX_Rt_i!=0, and IDEX_Rt_i equal to IFID_Rs_i or IFID_Rt_i.
REQ-017 Load-use is evaluated only in RUN.
REQ-018 On load-use in RUN: PC_Write_o=0, IFID_Write_o=0, ID_Flush_o=1 for that cycle; next state LU_STALL.
REQ-019 LU_STALL SHALL last exactly one cycle with default outputs; next state RUN unless REQ-015 selects otherwise.
REQ-020 On branch_taken_i in RUN, LU_STALL or FLUSH: IF_Flush_o=ID_Flush_o=EX_Flush_o=1 for that cycle with PC_Write_o=1; next state FLUSH.
REQ-021 FLUSH SHALL last one cycle with default outputs; load-use is suppressed in FLUSH; next state RUN.
REQ-022 On mem_busy_i in any state: PC_Write_o=0, IFID_Write_o=0, no flushes; next state MEM_WAIT.
REQ-023 The block SHALL remain in MEM_WAIT while mem_busy_i=1, then return to RUN.
REQ-024 A branch_taken_i arriving while mem_busy_i=1 SHALL be ignored; upstream holds it stable.
REQ-025 A 5-bit saturating wait counter SHALL increment each MEM_WAIT cycle with mem_busy_i=1 and clear on leaving MEM_WAIT.
REQ-026 When the wait counter reaches MEM_TIMEOUT-1 with mem_busy_i still 1, timeout_o SHALL set and stay set until reset.

Reset
REQ-027 While rst_i=1: state RUN, wait counter 0, timeout_o 0.
REQ-028 While rst_i=1: PC_Write_o=0, IFID_Write_o=0, IF_Flush_o=ID_Flush_o=EX_Flush_o=1.
REQ-029 Reset asserted mid-stall or mid-wait SHALL abort to RUN at the next edge.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt_o (32) and flush_cnt_o (32).
REQ-031 stall_cnt_o SHALL count cycles with PC_Write_o=0; flush_cnt_o SHALL count branch flush events.
REQ-032 Both counters SHALL wrap modulo 2^32 and clear on reset.
REQ-033 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package pipe_ctrl_pkg SHALL hold the state enum and the register-number width constant (5).
REQ-035 Sub-module hz_perf_cnt (one 32-bit enabled wrapping counter) SHALL be instantiated twice under HAZARD_PERF_CNT_EN.

Verification
REQ-036 Load-use: RUN, MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> that cycle PC_Write=0, IFID_Write=0, ID_Flush=1; next cycle LU_STALL with defaults; then RUN.
REQ-037 Register $zero: MemRead=1, IDEX_Rt=0, IFID_Rt=0 -> no stall; state stays RUN.
REQ-038 Branch: branch_taken_i=1 in RUN -> all three flushes 1 for one cycle; FLUSH next; load-use match in FLUSH is ignored.
REQ-039 Priority: mem_busy_i=1, branch_taken_i=1 and load-use together -> freeze only, no flush; state MEM_WAIT.
REQ-040 Timeout: MEM_TIMEOUT=4, mem_busy_i high for 6 cycles -> timeout_o rises at the 4th busy cycle in MEM_WAIT and stays 1 after busy drops until rst_i.
REQ-041 Reset mid-wait: rst_i=1 during MEM_WAIT -> next cycle state_o=0, timeout_o=0, and perf counters 0 when enabled.
